ibex_fcvt_ws: RTL

IBEX_FCVT_WS -- requirements
Module: ibex_fcvt_ws

---
 rtl/ibex_fcvt_ws.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ibex_fcvt_ws.sv
// Iterative binary32 -> int32/uint32 converter (FCVT.W.S / FCVT.WU.S) using a left-shifting window.
// Define IBEX_FCVT_UNSIGNED_EN to honour signed_i; otherwise every conversion is signed.
module ibex_fcvt_ws #(
  parameter int unsigned ShiftStep = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] operand_i,
  input  logic [2:0]  rnd_mode_i,
  input  logic [2:0]  frm_i,
  input  logic        signed_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  fflags_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [5:0] STEP = 6'(ShiftStep);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_DONE} state_e;

  state_e             r_state, w_next;
  logic [87:0]        r_w;
  logic [5:0]         r_c;
  logic signed [9:0]  r_e;
  logic               r_sign, r_nan, r_nz;
  logic [2:0]         r_rm;
  logic [31:0]        r_result;
  logic [4:0]         r_fflags;
`ifdef IBEX_FCVT_UNSIGNED_EN
  logic               r_signed;
`else
  logic               w_unused_signed;
  assign w_unused_signed = signed_i;
`endif

  logic [7:0]         w_exp;
  logic signed [9:0]  w_e;
  logic               w_in_rng, w_accept;
  logic [5:0]         w_c, w_step;
  logic [2:0]         w_rm_raw, w_rm;

  // Handshake: an operand transfers on valid_i & ready_o unless kill_i is high;
  // a result transfers on valid_o & ready_i and is held unchanged until then.
  assign ready_o     = (r_state == S_IDLE);
  assign valid_o     = (r_state == S_DONE);
  assign result_o    = r_result;
  assign fflags_o    = r_fflags;
  assign dbg_state_o = r_state;

  assign w_exp    = operand_i[30:23];
  assign w_e      = $signed({2'b00, w_exp}) - 10'sd127;
  assign w_in_rng = (w_e >= -10'sd1) && (w_e <= 10'sd31);
  assign w_c      = w_in_rng ? 6'(w_e + 10'sd1) : 6'd0;
  // DYN defers to frm_i; anything still not a real mode falls back to RNE.
  assign w_rm_raw = (rnd_mode_i == 3'd7) ? frm_i : rnd_mode_i;
  assign w_rm     = (w_rm_raw > 3'd4) ? 3'd0 : w_rm_raw;
  assign w_accept = valid_i & ready_o & ~kill_i;
  assign w_step   = (r_c < STEP) ? r_c : STEP;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (kill_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (valid_i) w_next = (w_c != 6'd0) ? S_SHIFT : S_ROUND;
        S_SHIFT: if (r_c <= STEP) w_next = S_ROUND;
        S_ROUND: w_next = S_DONE;
        S_DONE:  if (ready_i) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  logic [31:0] w_m, w_res;
  logic        w_g, w_s, w_tiny, w_big, w_pos, w_inc, w_nv, w_nx;
  logic [32:0] w_mag;

  always_comb begin
    // Magnitudes below 0.5 never reach the guard bit, so they only count as sticky.
    w_tiny = (r_e < -10'sd1) & r_nz;
    w_m    = w_tiny ? 32'd0 : r_w[87:56];
    w_g    = w_tiny ? 1'b0 : r_w[55];
    w_s    = w_tiny | (|r_w[54:0]);
    case (r_rm)
      3'd1:    w_inc = 1'b0;
      3'd2:    w_inc = r_sign & (w_g | w_s);
      3'd3:    w_inc = ~r_sign & (w_g | w_s);
      3'd4:    w_inc = w_g;
      default: w_inc = w_g & (w_s | w_m[0]);
    endcase
    w_mag = {1'b0, w_m} + {32'd0, w_inc};
    w_big = (r_e >= 10'sd32);
    w_pos = r_nan | ~r_sign;
    w_res = 32'd0;
    w_nv  = 1'b0;
`ifdef IBEX_FCVT_UNSIGNED_EN
    if (!r_signed) begin
      if (w_big) begin
        w_nv  = 1'b1;
        w_res = w_pos ? 32'hFFFF_FFFF : 32'd0;
      end else if (!r_sign) begin
        if (w_mag[32]) begin
          w_nv  = 1'b1;
          w_res = 32'hFFFF_FFFF;
        end else begin
          w_res = w_mag[31:0];
        end
      end else if (w_mag != 33'd0) begin
        w_nv = 1'b1;
      end
    end else
`endif
    begin
      if (w_big) begin
        w_nv  = 1'b1;
        w_res = w_pos ? 32'h7FFF_FFFF : 32'h8000_0000;
      end else if (!r_sign) begin
        if (w_mag > 33'h0_7FFF_FFFF) begin
          w_nv  = 1'b1;
          w_res = 32'h7FFF_FFFF;
        end else begin
          w_res = w_mag[31:0];
        end
      end else begin
        if (w_mag > 33'h0_8000_0000) begin
          w_nv  = 1'b1;
          w_res = 32'h8000_0000;
        end else begin
          w_res = 32'd0 - w_mag[31:0];
        end
      end
    end
    w_nx = ~w_nv & (w_g | w_s);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_w      <= '0;
      r_c      <= '0;
      r_e      <= '0;
      r_sign   <= 1'b0;
      r_nan    <= 1'b0;
      r_nz     <= 1'b0;
      r_rm     <= '0;
      r_result <= '0;
      r_fflags <= '0;
`ifdef IBEX_FCVT_UNSIGNED_EN
      r_signed <= 1'b1;
`endif
    end else if (w_accept) begin
      r_w    <= {32'd0, |w_exp, operand_i[22:0], 32'd0};
      r_c    <= w_c;
      r_e    <= w_e;
      r_sign <= operand_i[31];
      r_nan  <= (w_exp == 8'hFF) & (|operand_i[22:0]);
      r_nz   <= |operand_i[30:0];
      r_rm   <= w_rm;
`ifdef IBEX_FCVT_UNSIGNED_EN
      r_signed <= signed_i;
`endif
    end else if (r_state == S_SHIFT && !kill_i) begin
      r_w <= r_w << w_step;
      r_c <= r_c - w_step;
    end else if (r_state == S_ROUND && !kill_i) begin
      r_result <= w_res;
      r_fflags <= {w_nv, 3'b000, w_nx};
    end
  end

endmodule
